// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control unit: opcodes,
// FSM state encoding, datapath select codes and the bundled control word.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0111;
    localparam logic [3:0] OP_SW    = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BNE   = 4'b1010;
    localparam logic [3:0] OP_BLT   = 4'b1011;
    localparam logic [3:0] OP_BGT   = 4'b1100;
    localparam logic [3:0] OP_J     = 4'b1101;

    localparam logic [3:0] ALU_ADD  = 4'b0001;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_ALU_WB    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       sign_ext;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // State that follows DECODE for a given low opcode nibble; FETCH marks illegal.
    function automatic state_e decode_target(input logic [3:0] opc);
        case (opc)
            OP_RTYPE:                       return ST_EXEC_R;
            OP_ADDI, OP_ORI:                return ST_EXEC_I;
            OP_LW, OP_SW:                   return ST_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT: return ST_BRANCH;
            OP_J:                           return ST_JUMP;
            default:                        return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit (master) and the instruction register /
// datapath side (slave).
interface multicycle_control_unit_if #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic [OP_W-1:0]    op;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               IRWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               SignExt;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic               illegal_op;
    logic [CNT_W-1:0]   instr_count;
    logic [3:0]         state;

    modport master (
        input  op, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, SignExt, ALUSrcB,
               PCSource, ALUOp, illegal_op, instr_count, state
    );

    modport slave (
        output op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, SignExt, ALUSrcB,
               PCSource, ALUOp, illegal_op, instr_count, state
    );

endinterface

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state and opcode to datapath controls. Only
// FETCH looks at mem_ready, and only DECODE looks at the live opcode.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4
) (
    input  state_e             state_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [OP_W-1:0]    op_q_i,
    input  logic               mem_ready_i,
    output ctrl_t              ctrl_o,
    output logic [ALUOP_W-1:0] alu_op_o
);

    logic op_upper_zero;
    assign op_upper_zero = ((op_i >> 4) == '0);

    always_comb begin
        ctrl_o   = '0;
        alu_op_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                alu_op_o         = ALUOP_W'(ALU_ADD);
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.sign_ext   = 1'b1;
                ctrl_o.illegal_op = !op_upper_zero ||
                                    (decode_target(op_i[3:0]) == ST_FETCH);
                alu_op_o          = ALUOP_W'(ALU_ADD);
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
            end
            ST_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.sign_ext  = (op_q_i[3:0] == OP_ADDI);
                alu_op_o         = ALUOP_W'(op_q_i);
            end
            ST_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = (op_q_i[3:0] == OP_RTYPE);
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.sign_ext  = 1'b1;
                alu_op_o         = ALUOP_W'(op_q_i);
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                alu_op_o             = ALUOP_W'(op_q_i);
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: state register, latched opcode and
// retired-instruction counter; output decoding lives in ctrl_output_decode.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;
    ctrl_t              ctrl, ctrl_g;
    logic [ALUOP_W-1:0] alu_op;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = bus.op;
                state_d = ((bus.op >> 4) == '0) ? decode_target(bus.op[3:0]) : ST_FETCH;
            end
            ST_EXEC_R,
            ST_EXEC_I:   state_d = ST_ALU_WB;
            ST_MEM_ADDR: state_d = (op_q[3:0] == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: if (bus.mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_ALU_WB,
            ST_MEM_WB,
            ST_BRANCH,
            ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = ST_FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    ctrl_output_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .state_i     (state_q),
        .op_i        (bus.op),
        .op_q_i      (op_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl),
        .alu_op_o    (alu_op)
    );

    // Reset forces every output low, including the mem_ready-gated FETCH ones.
    assign ctrl_g = rst ? '0 : ctrl;

    assign bus.PCWrite     = ctrl_g.pc_write;
    assign bus.PCWriteCond = ctrl_g.pc_write_cond;
    assign bus.IorD        = ctrl_g.iord;
    assign bus.IRWrite     = ctrl_g.ir_write;
    assign bus.MemRead     = ctrl_g.mem_read;
    assign bus.MemWrite    = ctrl_g.mem_write;
    assign bus.MemToReg    = ctrl_g.mem_to_reg;
    assign bus.RegDst      = ctrl_g.reg_dst;
    assign bus.RegWrite    = ctrl_g.reg_write;
    assign bus.ALUSrcA     = ctrl_g.alu_src_a;
    assign bus.SignExt     = ctrl_g.sign_ext;
    assign bus.ALUSrcB     = ctrl_g.alu_src_b;
    assign bus.PCSource    = ctrl_g.pc_source;
    assign bus.illegal_op  = ctrl_g.illegal_op;
    assign bus.ALUOp       = rst ? '0 : alu_op;
    assign bus.instr_count = rst ? '0 : cnt_q;
    assign bus.state       = rst ? 4'd0 : state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath enables, multiplexer selects and ALU operation from a registered state machine. Memory accesses stall on a `mem_ready` handshake, and a retired-instruction counter is kept for bring-up. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
Parameters:
- `OP_W`, default 4: opcode width. Must be ≥ 4; only the low 4 bits are decoded, and upper bits must be 0 or the opcode is illegal.
- `ALUOP_W`, default 4: ALU operation width, ≥ 4.
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `op`, in, `OP_W`: opcode field from the instruction register. Sampled in DECODE.
- `mem_ready`, in, 1: memory completes the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `IRWrite`, `MemRead`, `MemWrite`, `MemToReg`, `RegDst`, `RegWrite`, `ALUSrcA`, `SignExt`, out, 1 each: datapath controls.
- `ALUSrcB`, out, 2: ALU B select. 0 = register B, 1 = constant 1, 2 = immediate.
- `PCSource`, out, 2: PC select. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `ALUOp`, out, `ALUOP_W`: ALU operation.
- `illegal_op`, out, 1: one-cycle pulse when an undecodable opcode is seen.
- `instr_count`, out, `CNT_W`: instructions retired.
- `state`, out, 4: current state, for debug.

## Operation
Opcodes (low 4 bits):
- 0000 R-type, 0001 addi, 0011 ori, 0111 lw, 1000 sw.
- 1001 beq, 1010 bne, 1011 blt, 1100 bgt, 1101 j.
- All other values are illegal.

States and transitions:
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=0001, `PCSource`=0.
  - `IRWrite` and `PCWrite` = `mem_ready` (combinational).
  - Stay in FETCH until `mem_ready`=1, then go to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=2, `SignExt`=1, `ALUOp`=0001 (branch-target precompute).
  - Next state by opcode: R → EXEC_R; addi/ori → EXEC_I; lw/sw → MEM_ADDR; branches → BRANCH; j → JUMP.
  - Illegal opcode → FETCH, with `illegal_op`=1 for that cycle; not counted as retired.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=0000 → ALU_WB.
- EXEC_I: `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=opcode, `SignExt`=1 for addi and 0 for ori → ALU_WB.
- ALU_WB: `RegWrite`=1, `MemToReg`=0, `RegDst`=1 for R-type and 0 for immediates → FETCH.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=2, `SignExt`=1, `ALUOp`=opcode → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `MemRead`=1, `IorD`=1. Holds until `mem_ready` → MEM_WB.
- MEM_WB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0 → FETCH.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Holds until `mem_ready` → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=opcode, `PCWriteCond`=1, `PCSource`=1 → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=2 → FETCH.

Output rules:
- `ALUOp`=opcode means the opcode zero-extended or truncated to `ALUOP_W`.
- Any output not listed for a state is 0.
- The opcode is latched in DECODE; later states use the latched copy, not `op`.

`instr_count`:
- Increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE, BRANCH or JUMP.
- Wraps modulo 2^`CNT_W`.

## Timing
- Reset: while `rst`=1 every output is 0, including the `mem_ready`-gated ones. The state register loads FETCH, `instr_count` and the latched opcode load 0. The first FETCH outputs appear in the cycle after `rst` falls.
- Reset asserted mid-instruction aborts it at the next edge. No `RegWrite` or `MemWrite` is issued after that edge.
- Latency with `mem_ready` always high:
  - R-type, addi, ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches and j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. `MemRead`/`MemWrite` and `IorD` stay stable during the stall.
- `mem_ready` is ignored in all other states.
- All outputs are decoded from the registered state (Moore), except FETCH `IRWrite` and `PCWrite`.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the opcode constants (`OP_RTYPE` … `OP_J`);
  - the state enum (4-bit);
  - the `ALUSrcB` and `PCSource` select constants;
  - `ALU_ADD`=0001.
- One natural sub-module, `ctrl_output_decode`: a combinational map from state, latched opcode and `mem_ready` to the outputs. The FSM and counter stay in the top module.

## Test plan
- Reset, then addi with `mem_ready`=1: states FETCH, DECODE, EXEC_I, ALU_WB. `RegWrite`=1 and `SignExt`=1 in the correct cycles; `instr_count`=1 after the 4th cycle.
- lw with `mem_ready` low for 2 cycles in FETCH and for 3 cycles in MEM_READ: total 10 cycles. `MemRead` and `IorD`=1 are held stable throughout the MEM_READ stall; `MemToReg`=1 in MEM_WB.
- beq, then j: BRANCH shows `PCWriteCond`=1, `PCSource`=1, `ALUOp`=1001; JUMP shows `PCWrite`=1, `PCSource`=2. `instr_count` rises by 2.
- Opcode 0101 in DECODE: `illegal_op` pulses for 1 cycle, return to FETCH, `instr_count` unchanged, and no write enable is asserted.
- Reset asserted in MEM_WRITE during a stall: `MemWrite`=0 from the next cycle, state is FETCH, `instr_count`=0.
- `CNT_W`=2 with 5 R-type instructions: `instr_count` sequence is 1, 2, 3, 0, 1.
